// File: rtl/uart_tx_arbiter.sv
// Arbitrates NUM_REQ packet sources onto one UART encoder packet port and paces
// transmission; define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MAX_BYTES  = 11,
    parameter int BIT_DIV    = 4,
    parameter int GUARD_BITS = 4
) (
    input  logic                           clock_4x,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_bytes,
    input  logic [NUM_REQ*4-1:0]           req_num_bytes,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           drop_err,
    output logic [MAX_BYTES*8-1:0]         tx_bytes,
    output logic [3:0]                     tx_num_bytes,
    output logic                           tx_valid,
    output logic                           busy
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = $clog2(2*BIT_DIV) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, WAIT} state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    win_sel;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [11:0]         wait_cnt;
    logic [11:0]         wait_load;
    logic [3:0]          sel_num;
    logic                sel_bad;

    // First requester found scanning upward from start, wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [IDX_W-1:0]   start);
        logic [IDX_W-1:0] w;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && r[idx]) begin
                w     = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

`ifdef UART_ARB_FIXED_PRIO_EN
    assign win_sel = pick(req, '0);
`else
    logic [IDX_W-1:0] rr_ptr;
    assign win_sel = pick(req, rr_ptr);

    always_ff @(posedge clock_4x or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (state == LOAD)
            rr_ptr <= (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
    end
`endif

    assign sel_num   = req_num_bytes[winner*4 +: 4];
    assign sel_bad   = (sel_num == 4'd0) || ({28'd0, sel_num} > 32'(MAX_BYTES));
    // 12 frame bit times per byte plus the guard gap, in clock_4x cycles.
    assign wait_load = (12'(tx_num_bytes) * 12'd12 + 12'(GUARD_BITS)) * 12'(BIT_DIV) - 12'd1;

    always_ff @(posedge clock_4x or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            winner       <= '0;
            hold_cnt     <= '0;
            wait_cnt     <= '0;
            tx_bytes     <= '0;
            tx_num_bytes <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: winner <= win_sel;
                LOAD: begin
                    hold_cnt <= HOLD_W'(2*BIT_DIV-1);
                    if (!sel_bad) begin
                        tx_bytes     <= req_bytes[winner*MAX_BYTES*8 +: MAX_BYTES*8];
                        tx_num_bytes <= sel_num;
                    end
                end
                STROBE: begin
                    if (hold_cnt == '0)
                        wait_cnt <= wait_load;
                    else
                        hold_cnt <= hold_cnt - 1'b1;
                end
                WAIT: begin
                    if (wait_cnt != 12'd0)
                        wait_cnt <= wait_cnt - 12'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        grant      = '0;
        drop_err   = 1'b0;
        tx_valid   = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (|req) state_next = LOAD;
            LOAD: begin
                grant[winner] = 1'b1;
                drop_err      = sel_bad;
                state_next    = sel_bad ? IDLE : STROBE;
            end
            // Strobe spans two encoder bit clocks so the encoder is sure to latch it.
            STROBE: begin
                tx_valid = 1'b1;
                if (hold_cnt == '0) state_next = WAIT;
            end
            WAIT: if (wait_cnt == 12'd0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with default parameters.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int MB = 11;
    localparam int PW = MB*8;

    logic              clock_4x = 1'b0;
    logic              reset    = 1'b1;
    logic [NR-1:0]     req      = '0;
    logic [NR*PW-1:0]  req_bytes = '0;
    logic [NR*4-1:0]   req_num_bytes = '0;
    logic [NR-1:0]     grant;
    logic              drop_err;
    logic [PW-1:0]     tx_bytes;
    logic [3:0]        tx_num_bytes;
    logic              tx_valid;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    int grants_q[$];
    int runs_q[$];
    int drops    = 0;
    int busy_run = 0;
    int val_cnt  = 0;
    int rises    = 0;
    logic prev_valid = 1'b0;

    uart_tx_arbiter dut (
        .clock_4x      (clock_4x),
        .reset         (reset),
        .req           (req),
        .req_bytes     (req_bytes),
        .req_num_bytes (req_num_bytes),
        .grant         (grant),
        .drop_err      (drop_err),
        .tx_bytes      (tx_bytes),
        .tx_num_bytes  (tx_num_bytes),
        .tx_valid      (tx_valid),
        .busy          (busy)
    );

    always #5 clock_4x = ~clock_4x;

    // Observe on the falling edge, away from the active edge.
    always @(negedge clock_4x) begin
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            runs_q.push_back(busy_run);
            busy_run = 0;
        end
        if (tx_valid) val_cnt++;
        if (tx_valid && !prev_valid) rises++;
        prev_valid = tx_valid;
        if (drop_err) drops++;
        for (int i = 0; i < NR; i++)
            if (grant[i]) grants_q.push_back(i);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_4x);
        #1;
    endtask

    task automatic clear_obs();
        grants_q.delete();
        runs_q.delete();
        drops   = 0;
        val_cnt = 0;
        rises   = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock_4x);
        #1;
        busy_run = 0;
        clear_obs();
        tick();
    endtask

    task automatic set_pkt(input int i, input logic [PW-1:0] b, input logic [3:0] n);
        req_bytes[i*PW +: PW] = b;
        req_num_bytes[i*4 +: 4] = n;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
        @(negedge clock_4x);
        #1;
    endtask

    task automatic wait_grants(input int cnt, input int max);
        int n = 0;
        while (grants_q.size() < cnt && n < max) begin
            tick();
            n++;
        end
        check("grant_timeout", grants_q.size(), cnt);
    endtask

    function automatic int q_at(input int k, input int which);
        if (which == 0) return (k < grants_q.size()) ? grants_q[k] : -1;
        return (k < runs_q.size()) ? runs_q[k] : -1;
    endfunction

    initial begin
        int exp_order[5];

        // Reset state
        #1;
        check("rst_grant", grant, 4'b0000);
        check("rst_drop", drop_err, 1'b0);
        check("rst_tx_bytes", tx_bytes, '0);
        check("rst_tx_num", tx_num_bytes, 4'd0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        do_reset();

        // Single valid request, 3 bytes
        set_pkt(1, {24'hA55A01, 64'h0}, 4'd3);
        req[1] = 1'b1;
        tick();
        check("single_grant", grant, 4'b0010);
        check("single_busy", busy, 1'b1);
        check("single_valid_early", tx_valid, 1'b0);
        req[1] = 1'b0;
        tick();
        check("single_valid", tx_valid, 1'b1);
        check("single_grant_pulse", grant, 4'b0000);
        check("single_bytes", tx_bytes[PW-1 -: 24], 24'hA55A01);
        check("single_num", tx_num_bytes, 4'd3);
        wait_idle(400);
        check("single_valid_len", val_cnt, 8);
        check("single_strobes", rises, 1);
        check("single_busy_len", q_at(0, 1), 169);
        check("single_bytes_held", tx_bytes[PW-1 -: 24], 24'hA55A01);

        // Contention, all requesters held with n=1
        do_reset();
        for (int i = 0; i < NR; i++) set_pkt(i, {8'(8'h10 + i), 80'h0}, 4'd1);
        req = 4'b1111;
        wait_grants(5, 600);
        req = 4'b0000;
        wait_idle(200);
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr_order%0d", k), q_at(k, 0), exp_order[k]);
            check($sformatf("rr_busy%0d", k), q_at(k, 1), 73);
        end
        check("rr_strobes", rises, 5);

        // Illegal lengths 0 and 12
        do_reset();
        set_pkt(2, {8'hEE, 80'h0}, 4'd0);
        req[2] = 1'b1;
        tick();
        check("len0_grant", grant, 4'b0100);
        check("len0_drop", drop_err, 1'b1);
        req[2] = 1'b0;
        tick();
        check("len0_busy", busy, 1'b0);
        set_pkt(2, {8'hEE, 80'h0}, 4'd12);
        req[2] = 1'b1;
        tick();
        check("len12_grant", grant, 4'b0100);
        check("len12_drop", drop_err, 1'b1);
        req[2] = 1'b0;
        wait_idle(20);
        check("bad_no_valid", val_cnt, 0);
        check("bad_drops", drops, 2);
        check("bad_busy0", q_at(0, 1), 1);
        check("bad_busy1", q_at(1, 1), 1);
        check("bad_tx_num", tx_num_bytes, 4'd0);

        // Maximum packet, second requester queued behind it
        do_reset();
        set_pkt(0, 88'hFFEEDDCCBBAA9988776655, 4'd11);
        set_pkt(1, {8'h42, 80'h0}, 4'd1);
        req[0] = 1'b1;
        tick();
        check("max_grant", grant, 4'b0001);
        req[0] = 1'b0;
        req[1] = 1'b1;
        tick();
        check("max_bytes", tx_bytes, 88'hFFEEDDCCBBAA9988776655);
        check("max_num", tx_num_bytes, 4'd11);
        wait_idle(700);
        check("max_busy", q_at(0, 1), 553);
        check("max_single_grant", grants_q.size(), 1);
        wait_grants(2, 10);
        check("max_next_grant", q_at(1, 0), 1);
        req[1] = 1'b0;
        wait_idle(200);

        // Reset during WAIT with a pending request
        do_reset();
        set_pkt(3, {16'h1234, 72'h0}, 4'd2);
        req[3] = 1'b1;
        tick();
        req[3] = 1'b0;
        for (int n = 0; n < 20 && (tx_valid || !busy); n++) tick();
        repeat (20) tick();
        check("wait_busy", busy, 1'b1);
        set_pkt(0, {8'h77, 80'h0}, 4'd1);
        req[0] = 1'b1;
        reset  = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_valid", tx_valid, 1'b0);
        check("midrst_grant", grant, 4'b0000);
        check("midrst_bytes", tx_bytes, '0);
        check("midrst_num", tx_num_bytes, 4'd0);
        #1;
        reset = 1'b0;
        tick();
        check("postrst_grant", grant, 4'b0001);
        req[0] = 1'b0;
        wait_idle(200);

        // Priority mode with req=1010 held
        do_reset();
        for (int i = 0; i < NR; i++) set_pkt(i, {8'h01, 80'h0}, 4'd1);
        req = 4'b1010;
        wait_grants(3, 400);
        req = 4'b0000;
        wait_idle(200);
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_order = '{1, 1, 1, 0, 0};
`else
        exp_order = '{1, 3, 1, 0, 0};
`endif
        for (int k = 0; k < 3; k++)
            check($sformatf("prio_order%0d", k), q_at(k, 0), exp_order[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
